eq_gain_sequencer: RTL and testbench

- Owns the three per-band attenuator gains of the graphic equalizer.
- Accepts user commands from the front-panel inputs: button `enter`, `band_select` and `level` switches.
  - Synchronises and debounces `enter`.
  - Latches a per-band target gain.
- Slews each live gain toward its target one step per audio sample tick, so gain changes do not cause zipper noise.
- Outputs drive the `val` inputs of the bass, mid and treble attenuators directly.

---
 rtl/eq_gain_sequencer_pkg.sv | 25 ++
 rtl/eq_gain_sequencer_slew.sv | 55 +++++
 rtl/eq_gain_sequencer.sv | 107 ++++++++++
 tb/tb_eq_gain_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/eq_gain_sequencer_pkg.sv
// eq_pkg: shared band codes, widths, command FSM states and level saturation for the EQ gain sequencer
package eq_pkg;

    localparam int GAIN_W  = 8;
    localparam int LEVEL_W = 10;

    localparam logic [GAIN_W-1:0] GAIN_MAX = 8'd255;

    localparam logic [1:0] BAND_BASS    = 2'd0;
    localparam logic [1:0] BAND_MID     = 2'd1;
    localparam logic [1:0] BAND_TREBLE  = 2'd2;
    localparam logic [1:0] BAND_INVALID = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        RELEASE
    } cmd_state_e;

    // Clamp a 10-bit front-panel level into the 8-bit gain range
    function automatic logic [GAIN_W-1:0] sat_level(input logic [LEVEL_W-1:0] level);
        return (level > {2'b00, GAIN_MAX}) ? GAIN_MAX : level[GAIN_W-1:0];
    endfunction

endpackage

// File: rtl/eq_gain_sequencer_slew.sv
// eq_gain_slew: one band's target/gain pair; slews by RAMP_STEP per tick with EQ_GAIN_SLEW_EN, else jumps on the tick
module eq_gain_slew
    import eq_pkg::*;
#(
    parameter int                RAMP_STEP  = 4,
    parameter logic [GAIN_W-1:0] RESET_GAIN = 8'd128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [GAIN_W-1:0] wdata_i,
    input  logic              tick_i,
    output logic [GAIN_W-1:0] gain_o,
    output logic              diff_o
);

    logic [GAIN_W-1:0] gain_q, gain_d, target_q, target_d;

    // A write lands in the target; the gain always moves toward the old target
    always_comb target_d = we_i ? wdata_i : target_q;

`ifdef EQ_GAIN_SLEW_EN
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);
    logic [GAIN_W-1:0] up, dn;

    // Clamped step toward the target; the clamp prevents overshoot and wrap
    always_comb begin
        up     = target_q - gain_q;
        dn     = gain_q - target_q;
        gain_d = gain_q;
        if (tick_i && gain_q < target_q)
            gain_d = gain_q + ((up > STEP) ? STEP : up);
        else if (tick_i && gain_q > target_q)
            gain_d = gain_q - ((dn > STEP) ? STEP : dn);
    end
`else
    // No slewing: the gain snaps to the target on the next sample tick
    always_comb gain_d = tick_i ? target_q : gain_q;
`endif

    // Gain and target registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_q   <= RESET_GAIN;
            target_q <= RESET_GAIN;
        end else begin
            gain_q   <= gain_d;
            target_q <= target_d;
        end
    end

    assign gain_o = gain_q;
    assign diff_o = gain_d != target_d;

endmodule

// File: rtl/eq_gain_sequencer.sv
// eq_gain_sequencer: enter synchroniser, debounce and command FSM driving three gain slewers (optional macro EQ_GAIN_SLEW_EN)
module eq_gain_sequencer
    import eq_pkg::*;
#(
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 16,
    parameter int                RAMP_STEP       = 4,
    parameter logic [GAIN_W-1:0] RESET_GAIN      = 8'd128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enter_i,
    input  logic [1:0]         band_select_i,
    input  logic [LEVEL_W-1:0] level_i,
    input  logic               sample_tick_i,
    output logic [GAIN_W-1:0]  bass_gain_o,
    output logic [GAIN_W-1:0]  mid_gain_o,
    output logic [GAIN_W-1:0]  treble_gain_o,
    output logic               cmd_ack_o,
    output logic               cmd_err_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   enter_s;
    cmd_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [1:0]             band_q;
    logic [GAIN_W-1:0]      sat_q;
    logic                   ack_q, err_q, busy_q;
    logic [2:0]             we, diff;
    logic [GAIN_W-1:0]      gain [3];

    assign enter_s = sync_q[SYNC_STAGES-1];

    // Metastability synchroniser for the raw push-button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], enter_i};
    end

    // Command FSM: band and level are captured on acceptance so ack/err line up with LATCH and the write follows it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            band_q  <= BAND_BASS;
            sat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (enter_s) begin
                    state_q <= LATCH;
                    band_q  <= band_select_i;
                    sat_q   <= sat_level(level_i);
                    ack_q   <= band_select_i != BAND_INVALID;
                    err_q   <= band_select_i == BAND_INVALID;
                end
                LATCH: begin
                    state_q <= RELEASE;
                    cnt_q   <= '0;
                end
                RELEASE: begin
                    if (enter_s)                                   cnt_q   <= '0;
                    else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) state_q <= IDLE;
                    else                                           cnt_q   <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Busy reflects next-state gain/target mismatch across all bands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= 1'b0;
        else        busy_q <= |diff;
    end

    for (genvar b = 0; b < 3; b++) begin : g_band
        assign we[b] = (state_q == LATCH) && (band_q == 2'(b));
        eq_gain_slew #(
            .RAMP_STEP  (RAMP_STEP),
            .RESET_GAIN (RESET_GAIN)
        ) u_slew (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (we[b]),
            .wdata_i (sat_q),
            .tick_i  (sample_tick_i),
            .gain_o  (gain[b]),
            .diff_o  (diff[b])
        );
    end

    assign bass_gain_o   = gain[BAND_BASS];
    assign mid_gain_o    = gain[BAND_MID];
    assign treble_gain_o = gain[BAND_TREBLE];
    assign cmd_ack_o     = ack_q;
    assign cmd_err_o     = err_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// tb_eq_gain_sequencer: directed plus random stimulus against a per-edge behavioural model of the gain sequencer
module tb_eq_gain_sequencer;

    localparam int RAMP = 4;
    localparam int DEB  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enter_i = 1'b0;
    logic [1:0] band_select_i = 2'd0;
    logic [9:0] level_i = 10'd0;
    logic       sample_tick_i = 1'b0;
    logic [7:0] bass_gain_o, mid_gain_o, treble_gain_o;
    logic       cmd_ack_o, cmd_err_o, busy_o;

    int total = 0;
    int bad = 0;
    int n_ack = 0;
    int n_err = 0;

    int m_gain [3];
    int m_tgt  [3];
    bit m_sh   [2];
    int m_phase, m_quiet, m_wr_b, m_wr_v;
    bit m_wr_pend, m_ack, m_err;

    always #5 clk = ~clk;

    eq_gain_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enter_i       (enter_i),
        .band_select_i (band_select_i),
        .level_i       (level_i),
        .sample_tick_i (sample_tick_i),
        .bass_gain_o   (bass_gain_o),
        .mid_gain_o    (mid_gain_o),
        .treble_gain_o (treble_gain_o),
        .cmd_ack_o     (cmd_ack_o),
        .cmd_err_o     (cmd_err_o),
        .busy_o        (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int toward(input int g, input int t);
`ifdef EQ_GAIN_SLEW_EN
        int d;
        d = t - g;
        if (d > RAMP)  d = RAMP;
        if (d < -RAMP) d = -RAMP;
        return g + d;
`else
        return t;
`endif
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_gain[b] = 128;
            m_tgt[b]  = 128;
        end
        m_sh[0] = 0; m_sh[1] = 0;
        m_phase = 0; m_quiet = 0; m_wr_pend = 0; m_ack = 0; m_err = 0;
    endtask

    task automatic check_outputs(input string tag);
        bit any;
        any = 0;
        for (int b = 0; b < 3; b++) any |= (m_gain[b] != m_tgt[b]);
        chk({tag, "_ack"},    32'(cmd_ack_o),     32'(m_ack));
        chk({tag, "_err"},    32'(cmd_err_o),     32'(m_err));
        chk({tag, "_bass"},   32'(bass_gain_o),   32'(m_gain[0]));
        chk({tag, "_mid"},    32'(mid_gain_o),    32'(m_gain[1]));
        chk({tag, "_treble"}, 32'(treble_gain_o), 32'(m_gain[2]));
        chk({tag, "_busy"},   32'(busy_o),        32'(any));
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare
    task automatic step(input string tag);
        bit es;
        int sat;
        @(posedge clk);
        es  = m_sh[1];
        sat = (level_i > 255) ? 255 : int'(level_i);
        if (sample_tick_i)
            for (int b = 0; b < 3; b++) m_gain[b] = toward(m_gain[b], m_tgt[b]);
        if (m_wr_pend) begin
            m_tgt[m_wr_b] = m_wr_v;
            m_wr_pend = 0;
        end
        m_ack = 0;
        m_err = 0;
        if (m_phase == 0) begin
            if (es) begin
                m_phase = 1;
                if (band_select_i != 2'd3) begin
                    m_ack = 1; m_wr_pend = 1; m_wr_b = int'(band_select_i); m_wr_v = sat;
                end else m_err = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_quiet = 0;
        end else if (es) m_quiet = 0;
        else begin
            m_quiet++;
            if (m_quiet == DEB) m_phase = 0;
        end
        m_sh[1] = m_sh[0];
        m_sh[0] = enter_i;
        #1;
        n_ack += int'(cmd_ack_o);
        n_err += int'(cmd_err_o);
        check_outputs(tag);
    endtask

    // per: 0 = no ticks, 1 = tick every cycle, n>1 = tick every n cycles, -1 = random ticks
    task automatic run(input string tag, input int n, input int per);
        for (int i = 0; i < n; i++) begin
            if (per == 0)      sample_tick_i = 1'b0;
            else if (per < 0)  sample_tick_i = ($urandom_range(2) == 0);
            else               sample_tick_i = (i % per == per - 1);
            step(tag);
        end
    endtask

    task automatic cmd(input string tag, input logic [1:0] band, input logic [9:0] lvl,
                       input int hold, input int after, input int per);
        band_select_i = band;
        level_i       = lvl;
        enter_i       = 1'b1;
        run(tag, hold, per);
        enter_i       = 1'b0;
        run(tag, after, per);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;
        run("post_reset", 5, 0);

        cmd("bass140", 2'd0, 10'd140, 3, 40, 4);
        chk("bass140_final", 32'(bass_gain_o), 32'd140);

        cmd("treble_sat", 2'd2, 10'd1000, 3, 100, 2);
        chk("treble_final", 32'(treble_gain_o), 32'd255);

        cmd("mid0", 2'd1, 10'd0, 3, 30, 10);
        cmd("mid200", 2'd1, 10'd200, 3, 60, 3);

        n_ack = 0;
        band_select_i = 2'd0;
        level_i = 10'd77;
        for (int i = 0; i < 10; i++) begin
            enter_i = (i % 2 == 0);
            run("bounce", 1, 0);
        end
        enter_i = 1'b1;
        run("bounce_hold", 30, 0);
        enter_i = 1'b0;
        run("bounce_rel", 30, 2);
        chk("bounce_one_ack", 32'(n_ack), 32'd1);

        n_err = 0;
        n_ack = 0;
        cmd("band3", 2'd3, 10'($urandom_range(1023)), 3, 30, 2);
        chk("band3_one_err", 32'(n_err), 32'd1);
        chk("band3_no_ack", 32'(n_ack), 32'd0);

        cmd("sat256", 2'd1, 10'd256, 3, 30, 1);
        chk("sat256_mid", 32'(mid_gain_o), 32'd255);

        band_select_i = 2'd0;
        level_i = 10'd20;
        enter_i = 1'b1;
        run("abort", 3, 0);
        enter_i = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs("abort_reset");
        rst_n = 1'b1;
        run("abort_after", 20, 1);

        for (int k = 0; k < 15; k++)
            cmd("rand", 2'($urandom_range(3)), 10'($urandom_range(1023)),
                $urandom_range(1, 4), $urandom_range(18, 40), (k % 3 == 0) ? 1 : -1);
        run("settle", 80, 1);
        chk("settle_idle", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
